// File: rtl/jericalla_pkg.sv
// Shared definitions for the jericalla instruction fetch sequencer:
// instruction width, default store geometry and the fetch FSM encoding.
package jericalla_pkg;

  localparam int unsigned INSTR_W     = 17;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned DEF_DEPTH   = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/jericalla_prog_mem.sv
// Program store: DEPTH x INSTR_W words, synchronous write, registered read.
// The read register doubles as the presented instruction, so it is reset.
module jericalla_prog_mem
  import jericalla_pkg::*;
#(
  parameter int unsigned WORD_W = INSTR_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only loaded on a read strobe, so the word is held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/jericalla_fetch.sv
// Instruction sequencer: steps pc through a first..last window (wrapping),
// presents each stored word on a valid/ready handshake, optional ZF early stop.
module jericalla_fetch
  import jericalla_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_first,
  input  logic [ADDR_W-1:0]  pc_last,
  input  logic               stop_on_zf,
  input  logic               zf_in,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    issued
);

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] last_q;
  logic              stop_q;
  logic [ADDR_W:0]   issued_q;
  logic              idle;
  logic              accept;
  logic              run_end;

  assign idle    = (state == S_IDLE);
  assign accept  = (state == S_PRESENT) && instr_ready;
  assign run_end = (pc_q == last_q) || (stop_q && zf_in);

  jericalla_prog_mem #(
    .WORD_W (INSTR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_prog_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && idle),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (state == S_READ),
    .rd_addr (pc_q),
    .rd_data (instruction)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_READ;
      S_READ:    state_nxt = S_PRESENT;
      S_PRESENT: if (accept) state_nxt = run_end ? S_DONE : S_READ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Run configuration is captured only on an idle start; pc wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      last_q   <= '0;
      stop_q   <= 1'b0;
      issued_q <= '0;
    end else if (idle && start) begin
      pc_q     <= pc_first;
      last_q   <= pc_last;
      stop_q   <= stop_on_zf;
      issued_q <= '0;
    end else if (accept) begin
      issued_q <= issued_q + 1'b1;
      if (!run_end) begin
        pc_q <= pc_q + 1'b1;
      end
    end
  end

  assign instr_valid = (state == S_PRESENT);
  assign busy        = !idle;
  assign done        = (state == S_DONE);
  assign pc          = pc_q;
  assign issued      = issued_q;

endmodule

// File: tb/tb_jericalla_fetch.sv
// Randomized scoreboard bench for jericalla_fetch against a queue-based run model.
module tb_jericalla_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [16:0] wr_data = '0;
  logic        start = 1'b0;
  logic [4:0]  pc_first = '0;
  logic [4:0]  pc_last = '0;
  logic        stop_on_zf = 1'b0;
  logic        zf_in = 1'b0;
  logic [16:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic [5:0]  issued;

  jericalla_fetch #(.ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .pc_first(pc_first), .pc_last(pc_last), .stop_on_zf(stop_on_zf),
    .zf_in(zf_in), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .busy(busy), .done(done), .issued(issued)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] addr; logic [16:0] word; } exp_t;
  exp_t        exp_q[$];
  int unsigned exp_done_q[$];
  logic [16:0] mem_m [32];

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int zf_idx = -1;
  int ready_mode = 0;
  int stall_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected at %0t", name, $time);
  endtask

  // Expected run: every address from first, wrapping mod 32, until last or the ZF accept.
  task automatic model_run(input logic [4:0] first, input logic [4:0] last,
                           input logic stop, input int zidx);
    int unsigned a;
    int unsigned n;
    a = first;
    n = 0;
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back('{addr: a[4:0], word: mem_m[a]});
      n++;
      if (a == last || (stop && k == zidx)) break;
      a = (a + 1) % 32;
    end
    exp_done_q.push_back(n);
  endtask

  // Monitor and consumer: drives ready/zf, then checks what the DUT presents.
  always @(negedge clk) begin
    case (ready_mode)
      1: instr_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (instr_valid && acc_cnt == 1 && stall_cnt < 5) begin
          instr_ready = 1'b0;
          stall_cnt++;
        end else begin
          instr_ready = 1'b1;
        end
      end
      default: instr_ready = 1'b1;
    endcase
    zf_in = (acc_cnt == zf_idx);
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_valid");
      end else begin
        chk("pc", 32'(pc), 32'(exp_q[0].addr));
        chk("instruction", 32'(instruction), 32'(exp_q[0].word));
        if (instr_ready) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_done_q.size() == 0) fail_now("unexpected_done");
      else chk("issued_at_done", 32'(issued), exp_done_q.pop_front());
    end
  end

  task automatic write_word(input logic [4:0] a, input logic [16:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mem_m[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] first, input logic [4:0] last,
                          input logic stop, input int zidx, input int mode);
    @(negedge clk);
    zf_idx = zidx; ready_mode = mode; acc_cnt = 0; stall_cnt = 0;
    start = 1'b1; pc_first = first; pc_last = last; stop_on_zf = stop;
    model_run(first, last, stop, zidx);
    @(negedge clk);
    start = 1'b0;
    pc_first = $urandom(); pc_last = $urandom(); stop_on_zf = $urandom();
    chk("valid_after_1", 32'(instr_valid), 0);
    chk("busy_in_run", 32'(busy), 1);
    @(negedge clk);
    chk("valid_after_2", 32'(instr_valid), 1);
  endtask

  task automatic run(input logic [4:0] first, input logic [4:0] last,
                     input logic stop, input int zidx, input int mode, input bit inject);
    int d0;
    bit seen;
    d0 = done_cnt;
    do_start(first, last, stop, zidx, mode);
    if (inject) begin
      @(negedge clk);
      start = 1'b1; pc_first = 5'd20; pc_last = 5'd21; stop_on_zf = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = ~mem_m[5];
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(posedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) fail_now("done_timeout");
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_single_pulse", 32'(done), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1;
    chk("rst_instruction", 32'(instruction), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_issued", 32'(issued), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) write_word(5'(i), 17'($urandom()));
    write_word(5'd0, 17'b00110010010001101);

    run(5'd0, 5'd0, 1'b0, -1, 0, 1'b0);
    chk("single_issued", 32'(issued), 1);
    run(5'd0, 5'd3, 1'b0, -1, 2, 1'b0);
    chk("backpressure_issued", 32'(issued), 4);
    run(5'd30, 5'd1, 1'b0, -1, 0, 1'b0);
    chk("wrap_issued", 32'(issued), 4);
    run(5'd0, 5'd7, 1'b1, 2, 0, 1'b0);
    chk("zf_stop_issued", 32'(issued), 3);
    chk("zf_stop_pc", 32'(pc), 2);
    run(5'd0, 5'd7, 1'b0, 2, 0, 1'b0);
    chk("zf_ignored_issued", 32'(issued), 8);
    run(5'd3, 5'd3, 1'b1, 0, 1, 1'b0);
    chk("zf_on_last_issued", 32'(issued), 1);
    run(5'd0, 5'd15, 1'b0, -1, 1, 1'b1);
    run(5'd4, 5'd6, 1'b0, -1, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run(5'($urandom()), 5'($urandom()), 1'($urandom()), int'($urandom_range(0, 40)), 1, 1'b0);
    end

    // Reset while a word is presented: outputs clear immediately, no done.
    do_start(5'd0, 5'd7, 1'b0, -1, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_instruction", 32'(instruction), 0);
    chk("mid_rst_valid", 32'(instr_valid), 0);
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_issued", 32'(issued), 0);
    exp_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(5'd28, 5'd2, 1'b0, -1, 1, 1'b0);
    chk("post_rst_issued", 32'(issued), 7);

    chk("done_queue_drained", 32'(exp_done_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jericalla_fetch.md
Name: jericalla_fetch

Overview:
Instruction sequencer directly upstream of the jericalla datapath. It holds a small program store of 17-bit instruction words and steps a program counter through a start..end address window. It presents one instruction at a time on a valid/ready handshake that drives the datapath's instruction input. It can optionally stop early when the datapath reports a zero result (ZF).

Parameters:
INSTR_W, 17, instruction word width; must match the datapath instruction port.
ADDR_W, 5, program-store address width.
DEPTH, 32, program-store entries; must equal 2**ADDR_W.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  program-store write strobe; honoured only in IDLE.
wr_addr  input  ADDR_W  program-store write address.
wr_data  input  INSTR_W  program-store write data.
start  input  1  one-cycle request to run; sampled only in IDLE.
pc_first  input  ADDR_W  first address of the run; latched on start.
pc_last  input  ADDR_W  last address of the run, inclusive; latched on start.
stop_on_zf  input  1  when 1, ZF ends the run early; latched on start.
zf_in  input  1  ZF from the datapath; valid in the cycle an instruction is accepted.
instruction  output  INSTR_W  instruction word to the datapath.
instr_valid  output  1  instruction holds a valid word.
instr_ready  input  1  datapath or consumer accepts the word.
pc  output  ADDR_W  address of the word currently presented.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when a run ends.
issued  output  ADDR_W+1  count of words accepted in the current or last run.

Behaviour:
- Reset values (async, rst_n low): state IDLE; instruction 0; instr_valid 0; pc 0; busy 0; done 0; issued 0. Program-store contents are not reset.
- Program store: synchronous write. Read is synchronous with one-cycle latency: the read data is registered into instruction.
- FSM states: IDLE, READ, PRESENT, DONE.
- IDLE:
  - wr_en writes the store.
  - On start: latch pc_first, pc_last and stop_on_zf; set pc to pc_first; clear issued; go to READ.
  - If start and wr_en occur in the same cycle, both take effect.
- READ: issue the store read at pc. Next cycle: instruction takes the read data, instr_valid goes to 1, go to PRESENT. Start-to-first-valid latency is 2 cycles.
- PRESENT:
  - While instr_ready is 0, hold instruction, pc and instr_valid stable.
  - On instr_valid and instr_ready (accept): issued increments; instr_valid drops to 0 next cycle.
  - After an accept, go to DONE if pc == pc_last, or if the latched stop_on_zf is 1 and zf_in is 1. Otherwise pc increments and the FSM goes to READ.
  - Sustained throughput is therefore one word per 2 cycles.
- DONE: done pulses for 1 cycle, then go to IDLE. busy is 0 from IDLE onward.
- Wrap-around: if pc_last < pc_first, pc wraps modulo DEPTH (e.g. first 30, last 1 issues 30, 31, 0, 1). The maximum run is DEPTH words, which is why issued is ADDR_W+1 bits wide.
- Run-time input changes: start, wr_en and changes to pc_first, pc_last or stop_on_zf are ignored while busy.
- Early stop: ZF on the last address and a ZF early stop are the same outcome, a single done pulse.
- Reset mid-run: all outputs return to their reset values immediately, with no done pulse.
- Unknown (x/z) instruction bits are passed through unchanged; the block does not decode the instruction.

Decomposition:
- Shared package jericalla_pkg holds INSTR_W, the FSM state encoding, and the default ADDR_W and DEPTH.
- Sub-module jericalla_prog_mem: a DEPTH x INSTR_W store with synchronous write and synchronous registered read.
- The FSM, pc, and the issued counter stay in the top level.

Test Plan:
- Reset and single word: load addr 0 = 17'b00110010010001101; start with first=0, last=0 and ready tied to 1. Expected: instr_valid at cycle 2 carrying that word, then done pulses; issued = 1; busy returns to 0.
- Backpressure: run 0..3 with ready held low for 5 cycles on word 1. Expected: instruction and pc are stable throughout; issue order is 0, 1, 2, 3; issued = 4.
- Wrap-around: first=30, last=1. Expected: pc sequence 30, 31, 0, 1, then done; issued = 4.
- Early stop: stop_on_zf=1 with zf_in asserted on the accept at pc=2 of run 0..7. Expected: done follows, pc stops at 2, issued = 3. Repeating with stop_on_zf=0 gives issued = 8.
- Ignored requests: assert start and wr_en to addr 5 mid-run. Expected: the run is unaffected and the addr-5 contents are unchanged when read back in a later run.
- Async reset: drop rst_n during PRESENT. Expected: all outputs clear within the same cycle, no done pulse; a new start runs normally.
